// File: rtl/pipe_pkg.sv
// Shared pipeline types and constants for the fetch/decode boundary.
package pipe_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] RESET_PC  = 32'h0000_0000;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [XLEN-1:0] PC_STEP   = 32'd4;

  // IF/ID payload: instruction, its PC+4, and a liveness flag
  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc4;
    logic            valid;
  } ifid_t;

  // Sequential PC; wraps modulo 2^32
  function automatic logic [XLEN-1:0] pc_plus4(input logic [XLEN-1:0] pc);
    return pc + PC_STEP;
  endfunction

endpackage

// File: rtl/instr_fetch_stage_if.sv
// Control, instruction-memory and IF/ID signals of the fetch stage.
interface instr_fetch_stage_if;
  import pipe_pkg::*;

  logic            stall;
  logic            flush;
  logic            redirect_en;
  logic [XLEN-1:0] redirect_pc;
  logic [XLEN-1:0] imem_addr;
  logic            imem_rd;
  logic [XLEN-1:0] imem_data;
  logic [XLEN-1:0] ifid_instr;
  logic [XLEN-1:0] ifid_pc4;
  logic            ifid_valid;

  // Environment side: hazard unit, branch resolution, memory, decode
  modport master (
    output stall, flush, redirect_en, redirect_pc, imem_data,
    input  imem_addr, imem_rd, ifid_instr, ifid_pc4, ifid_valid
  );

  // Fetch stage side
  modport slave (
    input  stall, flush, redirect_en, redirect_pc, imem_data,
    output imem_addr, imem_rd, ifid_instr, ifid_pc4, ifid_valid
  );

endinterface

// File: rtl/fetch_skid_buffer.sv
// One-entry holding store for a response that lands while decode is stalled.
module fetch_skid_buffer
  import pipe_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  load,
  input  logic  clear,
  input  ifid_t din,
  output ifid_t dout,
  output logic  valid
);

  // Clear has priority over load so a squash always empties the entry
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout <= '0;
    end else if (clear) begin
      dout.valid <= 1'b0;
    end else if (load) begin
      dout <= din;
    end
  end

  assign valid = dout.valid;

endmodule

// File: rtl/instr_fetch_stage.sv
// IF stage: PC, fetch issue, response tracking, skid buffer and IF/ID register.
module instr_fetch_stage #(
  parameter logic [31:0] RESET_PC  = pipe_pkg::RESET_PC,
  parameter logic [31:0] NOP_INSTR = pipe_pkg::NOP_INSTR
) (
  input logic                clk,
  input logic                rst,
  instr_fetch_stage_if.slave bus
);
  import pipe_pkg::*;

  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] req_pc;
  logic            req_v;
  logic            issue;
  logic            kill;
  logic            skid_v;
  logic            skid_load;
  logic            skid_clear;
  ifid_t           resp;
  ifid_t           skid_q;
  ifid_t           ifid_q;

  assign issue      = !rst && !bus.stall;
  assign kill       = bus.redirect_en || bus.flush;
  assign resp       = '{instr: bus.imem_data, pc4: pc_plus4(req_pc), valid: 1'b1};
  assign skid_load  = !kill && bus.stall && req_v;
  assign skid_clear = kill || (!bus.stall && skid_v);

  assign bus.imem_addr = pc;
  assign bus.imem_rd   = issue;

  // PC and in-flight request tracking; redirect wins over stall and squashes the request
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc     <= RESET_PC;
      req_v  <= 1'b0;
      req_pc <= '0;
    end else begin
      if (bus.redirect_en) begin
        pc <= bus.redirect_pc;
      end else if (issue) begin
        pc <= pc_plus4(pc);
      end
      req_v <= issue && !bus.redirect_en;
      if (issue) begin
        req_pc <= pc;
      end
      if (bus.redirect_en) begin
        assert (bus.redirect_pc[1:0] == 2'b00);
      end
      assert (!(bus.stall && req_v && skid_v));
    end
  end

  fetch_skid_buffer u_skid (
    .clk   (clk),
    .rst   (rst),
    .load  (skid_load),
    .clear (skid_clear),
    .din   (resp),
    .dout  (skid_q),
    .valid (skid_v)
  );

  // IF/ID register: squash, hold, drain skid, take response, else bubble
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ifid_q <= '{instr: NOP_INSTR, pc4: '0, valid: 1'b0};
    end else if (kill) begin
      ifid_q.valid <= 1'b0;
      ifid_q.instr <= NOP_INSTR;
    end else if (bus.stall) begin
      ifid_q <= ifid_q;
    end else if (skid_v) begin
      ifid_q <= skid_q;
    end else if (req_v) begin
      ifid_q <= resp;
    end else begin
      ifid_q.valid <= 1'b0;
      ifid_q.instr <= NOP_INSTR;
    end
  end

  assign bus.ifid_instr = ifid_q.instr;
  assign bus.ifid_pc4   = ifid_q.pc4;
  assign bus.ifid_valid = ifid_q.valid;

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Bench for instr_fetch_stage: directed scenarios plus random control traffic
// checked against a transaction-queue model of the fetch stream.
module tb_instr_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0000;
  localparam logic [31:0] RPC = 32'h0000_0000;

  logic clk;
  logic rst;
  instr_fetch_stage_if bus ();

  instr_fetch_stage #(.RESET_PC(RPC), .NOP_INSTR(NOP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int unsigned n_cmp;
  int unsigned n_err;
  logic [31:0] key;

  // Model state: words whose responses are available, the fetch in flight, the PC
  logic [31:0] m_q[$];
  logic        m_inflight;
  logic [31:0] m_inflight_addr;
  logic [31:0] m_pc;
  logic        m_valid;
  logic [31:0] m_instr;
  logic [31:0] m_pc4;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ key;
  endfunction

  // Synchronous-read instruction memory, one cycle latency
  always @(posedge clk) begin
    if (bus.imem_rd) bus.imem_data <= mem_word(bus.imem_addr);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_ifid(input string tag);
    chk({tag, ".valid"}, 32'(bus.ifid_valid), 32'(m_valid));
    chk({tag, ".instr"}, bus.ifid_instr, m_instr);
    chk({tag, ".pc4"}, bus.ifid_pc4, m_pc4);
  endtask

  task automatic model_reset();
    m_q.delete();
    m_inflight = 1'b0;
    m_inflight_addr = '0;
    m_pc = RPC;
    m_valid = 1'b0;
    m_instr = NOP;
    m_pc4 = '0;
  endtask

  // Stream-level view of one clock edge
  task automatic model_edge(input logic s, input logic f, input logic r, input logic [31:0] rp);
    logic [31:0] a;
    if (m_inflight) m_q.push_back(m_inflight_addr);
    if (r || f) begin
      m_q.delete();
      m_valid = 1'b0;
      m_instr = NOP;
    end else if (!s) begin
      if (m_q.size() > 0) begin
        a = m_q.pop_front();
        m_valid = 1'b1;
        m_instr = mem_word(a);
        m_pc4 = a + 32'd4;
      end else begin
        m_valid = 1'b0;
        m_instr = NOP;
      end
    end
    m_inflight = !s && !r;
    m_inflight_addr = m_pc;
    if (r) m_pc = rp;
    else if (!s) m_pc = m_pc + 32'd4;
  endtask

  // One cycle: drive at negedge, check fetch outputs, clock, check IF/ID
  task automatic step(input string tag, input logic s, input logic f, input logic r,
                      input logic [31:0] rp);
    bus.stall = s;
    bus.flush = f;
    bus.redirect_en = r;
    bus.redirect_pc = rp;
    #1;
    chk({tag, ".imem_rd"}, 32'(bus.imem_rd), 32'(!s));
    chk({tag, ".imem_addr"}, bus.imem_addr, m_pc);
    @(posedge clk);
    model_edge(s, f, r, rp);
    @(negedge clk);
    check_ifid(tag);
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag, 1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, ".valid"}, 32'(bus.ifid_valid), 32'd0);
    chk({tag, ".instr"}, bus.ifid_instr, NOP);
    chk({tag, ".pc4"}, bus.ifid_pc4, 32'd0);
    chk({tag, ".imem_rd"}, 32'(bus.imem_rd), 32'd0);
    chk({tag, ".imem_addr"}, bus.imem_addr, RPC);
  endtask

  initial begin
    logic s, f, r;
    logic [31:0] rp;
    n_cmp = 0;
    n_err = 0;
    key = $urandom() & 32'hFFF0_0000;
    rst = 1'b1;
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    bus.redirect_en = 1'b0;
    bus.redirect_pc = '0;
    bus.imem_data = '0;
    model_reset();

    @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    idle("stream", 8);
    for (int i = 0; i < 3; i++) step("stall3", 1'b1, 1'b0, 1'b0, '0);
    idle("resume", 5);
    step("flush", 1'b0, 1'b1, 1'b0, '0);
    idle("post_flush", 4);
    step("redirect", 1'b0, 1'b0, 1'b1, 32'h0000_0100);
    idle("post_redirect", 4);
    step("redir_stall", 1'b1, 1'b0, 1'b1, 32'h0000_0100);
    step("redir_stall_hold", 1'b1, 1'b0, 1'b0, '0);
    idle("post_redir_stall", 4);
    step("wrap_redirect", 1'b0, 1'b0, 1'b1, 32'hFFFF_FFF8);
    idle("wrap", 6);

    for (int i = 0; i < 300; i++) begin
      s  = ($urandom_range(99) < 30);
      f  = ($urandom_range(99) < 8);
      r  = ($urandom_range(99) < 8);
      rp = $urandom() & 32'hFFFF_FFFC;
      step("random", s, f, r, rp);
    end
    idle("drain", 3);

    // Reset while stalled with a response parked in the skid
    idle("pre_rst", 3);
    step("stall_skid", 1'b1, 1'b0, 1'b0, '0);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_reset_outputs("mid_rst");
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs("mid_rst_held");
    rst = 1'b0;
    idle("restart", 6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
